serial_add_sched: RTL and testbench
===================================

// Module: serial_add_sched
// PURPOSE
//  Round-robin scheduler and sequencer that shares one bit-serial adder datapath among N_REQ requesters.
//  - Arbitrates the requesters and muxes the winner's operands onto the datapath.
//  - Drives the datapath load/clear/shift/counter controls.
//  - Captures the serial sum and carry, then returns them to the winner with a one-cycle ack.
//  Sits between the requesting blocks and the bit-serial adder datapath (shift regs, full adder, carry dff, counter).
// PARAMETERS
//  N_REQ  4                    number of requesters (>=2)
//  WIDTH  16                   operand/sum width in bits
//  CW     $clog2(WIDTH+1) (5)  datapath counter width
//  IDW    $clog2(N_REQ) (2)    requester id width
// PORTS
//  clk          in   1          single clock, all logic on posedge
//  rst          in   1          synchronous, active-high reset
//  req          in   N_REQ      per-requester request level; hold with operands stable until ack
//  a_in         in   N_REQ*W    packed operand A, requester i at [i*W +: W]
//  b_in         in   N_REQ*W    packed operand B, same packing
//  ack          out  N_REQ      one-hot, one-cycle pulse: result valid for that requester
//  result       out  WIDTH      sum of the completed operation, held until next DONE
//  result_cout  out  1          final carry of the completed operation
//  result_id    out  IDW        owner of result
//  busy         out  1          1 in every state except IDLE
//  dp_a, dp_b   out  WIDTH      operands of current owner, to datapath shift-reg load inputs
//  dp_ld        out  1          load both operand shift registers
//  dp_clr       out  1          clear sum register and carry dff
//  dp_ld_ctr    out  1          load datapath counter with dp_ctr_init
//  dp_ctr_init  out  CW         constant WIDTH-1
//  dp_shift     out  1          right-shift operands/sum, update carry
//  dp_dec_ctr   out  1          decrement datapath counter
//  dp_eqz       in   1          datapath counter == 0
//  dp_sum       in   WIDTH      datapath sum register
//  dp_carry     in   1          datapath carry dff output
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, owner=0, all outputs 0 (ack, busy, result, result_cout, result_id, all dp_* controls).
//  FSM IDLE -> LOAD -> SHIFT -> DONE -> IDLE; controls below are combinational from state.
//  - IDLE: if req!=0, pick the first set bit at or after the pointer (wrapping); register owner; go to LOAD.
//    Nothing is asserted.
//  - LOAD (1 cycle): dp_ld=dp_clr=dp_ld_ctr=1; go to SHIFT.
//  - SHIFT: dp_shift=dp_dec_ctr=1 every cycle; leave to DONE in the cycle dp_eqz=1.
//    That cycle also shifts, giving exactly WIDTH shifts.
//  - DONE (1 cycle): result<=dp_sum, result_cout<=dp_carry, result_id<=owner (registered, visible the cycle after DONE);
//    ack[owner]=1 combinationally during DONE; pointer<=owner+1 mod N_REQ; go to IDLE.
//    Requester samples result/result_cout on the cycle after its ack.
//  Latency: req seen in IDLE at cycle t -> ack at cycle t+WIDTH+2; back-to-back ops every WIDTH+3 cycles.
//  dp_a/dp_b = operands of owner in all states (mux on the registered owner, not the live grant).
//  Boundaries:
//  - req drop after grant: ignored; the op completes and ack still pulses.
//  - req drop before grant: no op.
//  - New req during an op: waits; it is not visible until IDLE.
//  - Simultaneous reqs: rr order; a requester holding req continuously is served at most once per N_REQ grants if others wait.
//  - Carry-out of the MSB add is reported in result_cout; sum wraps mod 2^WIDTH.
//  - rst mid-operation: immediate IDLE next cycle, no ack, result cleared, datapath controls deasserted; pointer=0.
//  - dp_eqz is ignored outside SHIFT.
// STRUCTURE
//  - Shared package serial_pkg: state encoding (IDLE=0, LOAD=1, SHIFT=2, DONE=3, 2 bits); WIDTH/CW defaults.
//  - Sub-module rr_arbiter (N_REQ): inputs req and ptr; output one-hot gnt and encoded gnt_id; purely combinational.
//  - Top holds the FSM, owner/pointer/result registers and the operand mux.
// TESTING (bench includes a behavioural bit-serial datapath model)
//  1. Single op, WIDTH=16: req[0], A=16'h1234, B=16'h0F0F at t -> ack=4'b0001 at t+18; result=16'h2143, cout=0.
//  2. Overflow: req[2], A=16'hFFFF, B=16'h0001 -> result=16'h0000, result_cout=1, result_id=2.
//  3. Contention: req=4'b1111 held -> acks 0,1,2,3,0 in order, spaced 19 cycles.
//  4. RR fairness: after serving req1, req=4'b0011 -> next grant id 0 (wrap from pointer 2).
//  5. Reset mid-op: rst for 1 cycle during SHIFT -> busy=0, no ack, all dp_* 0; next req is served from IDLE normally.
//  6. req drop: req[3] deasserted in LOAD -> ack[3] still pulses; result correct.

Source files
------------

// File: rtl/serial_add_sched_pkg.sv
// Shared types and defaults for the bit-serial adder scheduler.
// Holds the FSM state encoding and the round-robin index helper.
package serial_add_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 16;
  localparam int CW_DEF    = $clog2(WIDTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int rr_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/serial_add_sched_if.sv
// Requester-side bus: level requests with packed operands in, one-hot ack with result out.
// The ack pulses for one cycle; the result is stable from the cycle after the ack.
interface serial_add_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       result;
  logic                   result_cout;
  logic [IDW-1:0]         result_id;

  modport master (
    output req, a_in, b_in,
    input  ack, result, result_cout, result_id
  );

  modport slave (
    input  req, a_in, b_in,
    output ack, result, result_cout, result_id
  );
endinterface

// File: rtl/serial_add_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Zero latency; gnt is all-zero when no request is pending.
module rr_arbiter
  import serial_add_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IDW'(rr_idx(int'(ptr), i, N_REQ));
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_id     = idx;
      end
    end
  end

endmodule

// File: rtl/serial_add_sched.sv
// Shares one bit-serial adder among N_REQ requesters: arbitrate, load, shift WIDTH times, return sum.
// req sampled in IDLE at cycle t gives ack at t+WIDTH+2; requests wait while busy.
module serial_add_sched
  import serial_add_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH + 1),
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_sched_if.slave bus,
  output logic              busy,
  output logic [WIDTH-1:0]  dp_a,
  output logic [WIDTH-1:0]  dp_b,
  output logic              dp_ld,
  output logic              dp_clr,
  output logic              dp_ld_ctr,
  output logic [CW-1:0]     dp_ctr_init,
  output logic              dp_shift,
  output logic              dp_dec_ctr,
  input  logic              dp_eqz,
  input  logic [WIDTH-1:0]  dp_sum,
  input  logic              dp_carry
);

  state_t           state;
  logic [IDW-1:0]   owner;
  logic [IDW-1:0]   ptr;
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_id;

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req    (bus.req),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= '0;
      ptr             <= '0;
      bus.result      <= '0;
      bus.result_cout <= 1'b0;
      bus.result_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner <= gnt_id;
            state <= LOAD;
          end
        end
        LOAD:  state <= SHIFT;
        // The cycle that sees the counter at zero still shifts: WIDTH shifts in total.
        SHIFT: if (dp_eqz) state <= DONE;
        DONE: begin
          bus.result      <= dp_sum;
          bus.result_cout <= dp_carry;
          bus.result_id   <= owner;
          ptr             <= IDW'(rr_idx(int'(owner), 1, N_REQ));
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    dp_ld      = (state == LOAD);
    dp_clr     = (state == LOAD);
    dp_ld_ctr  = (state == LOAD);
    dp_shift   = (state == SHIFT);
    dp_dec_ctr = (state == SHIFT);
    bus.ack    = '0;
    if (state == DONE) bus.ack[owner] = 1'b1;
  end

  // Operands follow the registered owner so a late req change cannot disturb the load.
  assign dp_a        = bus.a_in[owner*WIDTH +: WIDTH];
  assign dp_b        = bus.b_in[owner*WIDTH +: WIDTH];
  assign dp_ctr_init = CW'(WIDTH - 1);

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched with a behavioural bit-serial datapath model.
module tb_serial_add_sched;

  localparam int N = 4;
  localparam int W = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  logic busy, dp_ld, dp_clr, dp_ld_ctr, dp_shift, dp_dec_ctr, dp_eqz, dp_carry;
  logic [W-1:0] dp_a, dp_b, dp_sum;
  logic [CW-1:0] dp_ctr_init;

  serial_add_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();

  serial_add_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .dp_a        (dp_a),
    .dp_b        (dp_b),
    .dp_ld       (dp_ld),
    .dp_clr      (dp_clr),
    .dp_ld_ctr   (dp_ld_ctr),
    .dp_ctr_init (dp_ctr_init),
    .dp_shift    (dp_shift),
    .dp_dec_ctr  (dp_dec_ctr),
    .dp_eqz      (dp_eqz),
    .dp_sum      (dp_sum),
    .dp_carry    (dp_carry)
  );

  always #5 clk = ~clk;

  // Bit-serial datapath: operand shift regs, full adder, carry dff, down counter.
  logic [W-1:0]  m_a, m_b, m_sum;
  logic          m_c;
  logic [CW-1:0] m_ctr;
  always @(posedge clk) begin
    if (rst) begin
      m_a <= '0; m_b <= '0; m_sum <= '0; m_c <= 1'b0; m_ctr <= '0;
    end else begin
      if (dp_ld) begin m_a <= dp_a; m_b <= dp_b; end
      if (dp_clr) begin m_sum <= '0; m_c <= 1'b0; end
      if (dp_ld_ctr) m_ctr <= dp_ctr_init;
      if (dp_shift) begin
        m_a   <= m_a >> 1;
        m_b   <= m_b >> 1;
        m_sum <= {m_a[0] ^ m_b[0] ^ m_c, m_sum[W-1:1]};
        m_c   <= (m_a[0] & m_b[0]) | (m_c & (m_a[0] ^ m_b[0]));
      end
      if (dp_dec_ctr) m_ctr <= m_ctr - 1'b1;
    end
  end
  assign dp_sum   = m_sum;
  assign dp_carry = m_c;
  assign dp_eqz   = (m_ctr == '0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int ack_cyc, prev_cyc, c0, n_ack;
  logic ack_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in[id*W +: W] = a;
    bus.b_in[id*W +: W] = b;
  endtask

  task automatic wait_ack(input int maxc);
    ack_seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        ack_seen = 1'b1;
        ack_cyc  = cyc;
        break;
      end
    end
    if (!ack_seen) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [4:0] ctrls();
    return {dp_ld, dp_clr, dp_ld_ctr, dp_shift, dp_dec_ctr};
  endfunction

  logic [W-1:0] exp_sum [N];
  logic         exp_c   [N];
  int           exp_id  [5];

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_cout", 32'(bus.result_cout), 32'd0);
    chk("rst_id", 32'(bus.result_id), 32'd0);
    chk("rst_ctrl", 32'(ctrls()), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single operation with latency and control decode.
    set_op(0, 16'h1234, 16'h0F0F);
    c0 = cyc;
    bus.req = 4'b0001;
    @(posedge clk); #1;
    chk("t1_load_ctrl", 32'(ctrls()), 32'b11100);
    chk("t1_dp_a", 32'(dp_a), 32'h1234);
    chk("t1_dp_b", 32'(dp_b), 32'h0F0F);
    chk("t1_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("t1_shift_ctrl", 32'(ctrls()), 32'b00011);
    wait_ack(40);
    chk("t1_latency", 32'(ack_cyc - c0), 32'd18);
    chk("t1_ack", 32'(bus.ack), 32'b0001);
    bus.req = '0;
    @(posedge clk); #1;
    chk("t1_result", 32'(bus.result), 32'h2143);
    chk("t1_cout", 32'(bus.result_cout), 32'd0);
    chk("t1_id", 32'(bus.result_id), 32'd0);
    chk("t1_ack_off", 32'(bus.ack), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Overflow on requester 2.
    set_op(2, 16'hFFFF, 16'h0001);
    c0 = cyc;
    bus.req = 4'b0100;
    wait_ack(40);
    chk("t2_latency", 32'(ack_cyc - c0), 32'd18);
    chk("t2_ack", 32'(bus.ack), 32'b0100);
    bus.req = '0;
    @(posedge clk); #1;
    chk("t2_result", 32'(bus.result), 32'h0000);
    chk("t2_cout", 32'(bus.result_cout), 32'd1);
    chk("t2_id", 32'(bus.result_id), 32'd2);

    // Contention from pointer 0, then fairness wrap.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_op(0, 16'h0001, 16'h0002); exp_sum[0] = 16'h0003; exp_c[0] = 1'b0;
    set_op(1, 16'h8000, 16'h8000); exp_sum[1] = 16'h0000; exp_c[1] = 1'b1;
    set_op(2, 16'h1111, 16'h2222); exp_sum[2] = 16'h3333; exp_c[2] = 1'b0;
    set_op(3, 16'h00FF, 16'h0F00); exp_sum[3] = 16'h0FFF; exp_c[3] = 1'b0;
    exp_id = '{0, 1, 2, 3, 0};
    bus.req = 4'b1111;
    prev_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ack(40);
      chk($sformatf("t3_ack%0d", i), 32'(bus.ack), 32'd1 << exp_id[i]);
      if (i > 0) chk($sformatf("t3_gap%0d", i), 32'(ack_cyc - prev_cyc), 32'd19);
      prev_cyc = ack_cyc;
      if (i == 4) bus.req = 4'b0010;
      @(posedge clk); #1;
      chk($sformatf("t3_res%0d", i), 32'(bus.result), 32'(exp_sum[exp_id[i]]));
      chk($sformatf("t3_cout%0d", i), 32'(bus.result_cout), 32'(exp_c[exp_id[i]]));
    end
    wait_ack(40);
    chk("t4_ack1", 32'(bus.ack), 32'b0010);
    bus.req = 4'b0011;
    @(posedge clk); #1;
    wait_ack(40);
    chk("t4_wrap_ack0", 32'(bus.ack), 32'b0001);
    bus.req = '0;
    @(posedge clk); #1;
    chk("t4_id", 32'(bus.result_id), 32'd0);

    // Reset in the middle of SHIFT; pointer must return to 0.
    set_op(1, 16'hAAAA, 16'h5555);
    bus.req = 4'b0010;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_in_shift", 32'(ctrls()), 32'b00011);
    rst = 1'b1;
    bus.req = '0;
    @(posedge clk); #1 rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ack", 32'(bus.ack), 32'd0);
    chk("t5_ctrl", 32'(ctrls()), 32'd0);
    chk("t5_result", 32'(bus.result), 32'd0);
    n_ack = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.ack != '0) n_ack++;
    end
    chk("t5_no_ack", 32'(n_ack), 32'd0);
    @(posedge clk); #1;
    set_op(0, 16'h8001, 16'h8001);
    c0 = cyc;
    bus.req = 4'b1001;
    wait_ack(40);
    chk("t5_latency", 32'(ack_cyc - c0), 32'd18);
    chk("t5_ptr0_ack", 32'(bus.ack), 32'b0001);
    bus.req = '0;
    @(posedge clk); #1;
    chk("t5_result2", 32'(bus.result), 32'h0002);
    chk("t5_cout2", 32'(bus.result_cout), 32'd1);

    // req dropped during LOAD still completes.
    set_op(3, 16'h7FFF, 16'h7FFF);
    bus.req = 4'b1000;
    @(posedge clk); #1;
    bus.req = '0;
    wait_ack(40);
    chk("t6_ack", 32'(bus.ack), 32'b1000);
    @(posedge clk); #1;
    chk("t6_result", 32'(bus.result), 32'hFFFE);
    chk("t6_cout", 32'(bus.result_cout), 32'd0);
    chk("t6_id", 32'(bus.result_id), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
